// File: rtl/ocra_grad_pkg.sv
// Shared definitions for the ocra_grad_seq gradient sequencer: register map,
// CTRL/STATUS bit positions and FSM state encoding.
package ocra_grad_pkg;

   // Register offsets (low two bits of a register-space bus address)
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_INTERVAL = 2'd1;
   localparam logic [1:0] REG_END      = 2'd2;
   localparam logic [1:0] REG_STATUS   = 2'd3;

   // CTRL bits (write-only, act for one cycle)
   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_IRQ_CLR = 2;
   localparam int CTRL_LOOP    = 3;

   // STATUS bits
   localparam int ST_BUSY      = 0;
   localparam int ST_DONE      = 1;
   localparam int ST_UNDERRUN  = 2;
   localparam int ST_WRAP      = 3;
   localparam int ST_FRAME_LSB = 16;

   // Frame index width, matches the STATUS[31:16] field
   localparam int FRAME_W = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SEND  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/ocra_grad_seq_ram.sv
// Simple dual-port waveform RAM: one write port, one registered read port
// with 1-cycle latency. Contents are intentionally not reset.
module ocra_grad_seq_ram #(
   parameter int DATA_W = 16,
   parameter int AW     = 12
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(2**AW)-1];

   // Write port, owned by the host bus
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read port, owned by the sequencer; output holds when re_i is low
   always_ff @(posedge clk) begin
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/ocra_grad_seq.sv
// Multi-channel gradient waveform sequencer. Host loads samples into the
// waveform RAM and registers; on start, frames are replayed onto a
// channel-tagged valid/ready stream at a programmable frame period.
// Optional build macro GRAD_SEQ_LOOP_EN enables CTRL b3 loop playback and
// the STATUS b3 wrap_seen flag.
module ocra_grad_seq
   import ocra_grad_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int DATA_W     = 16,
   parameter int MEM_AW     = 12,
   parameter int INTERVAL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_we,
   input  logic              bus_re,
   input  logic [MEM_AW:0]   bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_rvalid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_ch,
   output logic [DATA_W-1:0] out_data,
   output logic              irq
);

   // Frame-period counter is one bit wider than INTERVAL so that
   // INTERVAL+CHANNELS never overflows.
   localparam int CNT_W = INTERVAL_W + 1;

   state_e                state_q, state_d;
   logic [FRAME_W-1:0]    frame_q, end_q;
   logic [2:0]            ch_q;
   logic [CNT_W-1:0]      cnt_q, period_m1;
   logic [INTERVAL_W-1:0] interval_q;
   logic                  done_q, und_q, irq_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q, rd_mux, status, lin_addr;
   logic [DATA_W-1:0]     ram_rdata;
   logic                  reg_wr, ram_we, ctrl_wr, start, abort, irq_clr;
   logic                  last_ch, frame_start, loop_act, wrap_bit;
   logic                  busy, send, ram_re;

   assign reg_wr  = bus_we & ~bus_addr[MEM_AW];
   assign ram_we  = bus_we &  bus_addr[MEM_AW];
   assign ctrl_wr = reg_wr && (bus_addr[1:0] == REG_CTRL);
   assign start   = ctrl_wr & bus_wdata[CTRL_START];
   assign abort   = ctrl_wr & bus_wdata[CTRL_ABORT];
   assign irq_clr = ctrl_wr & bus_wdata[CTRL_IRQ_CLR];

   assign last_ch   = (ch_q == 3'(CHANNELS - 1));
   // The counter is loaded at each frame start and runs down to zero, so
   // the distance between frame starts is INTERVAL+CHANNELS+1 cycles. That
   // is always at least 2, so the floor of 1 never binds.
   assign period_m1 = CNT_W'(interval_q) + CNT_W'(CHANNELS);
   // A frame starts whenever we enter FETCH from IDLE (start) or WAIT
   assign frame_start = (state_d == S_FETCH) &&
                        ((state_q == S_IDLE) || (state_q == S_WAIT));
   assign lin_addr    = 32'(frame_q) * 32'(CHANNELS) + 32'(ch_q);

`ifdef GRAD_SEQ_LOOP_EN
   logic loop_q, wrap_q;
   assign loop_act = loop_q;
   assign wrap_bit = wrap_q;

   // Loop mode latch and sticky wrap indicator
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         if (frame_start && state_q == S_IDLE) loop_q <= bus_wdata[CTRL_LOOP];
         if (irq_clr) wrap_q <= 1'b0;
         if (frame_start && state_q == S_WAIT && frame_q == end_q) wrap_q <= 1'b1;
      end
   end
`else
   assign loop_act = 1'b0;
   assign wrap_bit = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic; abort overrides everything, including start
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (out_ready) state_d = last_ch ? S_WAIT : S_FETCH;
            S_WAIT:  if (cnt_q == '0)
                        state_d = (frame_q == end_q && !loop_act) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      send   = (state_q == S_SEND);
      ram_re = (state_q == S_FETCH);
      busy   = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_WAIT);
   end

   // Frame/channel position and frame-period counter
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
         ch_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
         if (frame_start) begin
            cnt_q   <= period_m1;
            ch_q    <= '0;
            frame_q <= (state_q == S_IDLE || frame_q == end_q) ? '0 : frame_q + FRAME_W'(1);
         end else if (state_q == S_SEND && state_d == S_FETCH) begin
            ch_q <= ch_q + 3'd1;
         end
      end
   end

   // Sticky done/underrun flags and interrupt; new events beat irq_clr
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         und_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (irq_clr) begin
            done_q <= 1'b0;
            und_q  <= 1'b0;
            irq_q  <= 1'b0;
         end
         if (frame_start && state_q == S_IDLE) begin
            done_q <= 1'b0;
            und_q  <= 1'b0;
         end
         if (state_q == S_DONE && !abort) begin
            done_q <= 1'b1;
            irq_q  <= 1'b1;
         end
         if (send && cnt_q == '0 && !abort) begin
            und_q <= 1'b1;
            irq_q <= 1'b1;
         end
      end
   end

   // Host-writable configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         interval_q <= '0;
         end_q      <= '0;
      end else if (reg_wr) begin
         if (bus_addr[1:0] == REG_INTERVAL) interval_q <= bus_wdata[INTERVAL_W-1:0];
         if (bus_addr[1:0] == REG_END)      end_q      <= bus_wdata[FRAME_W-1:0];
      end
   end

   // STATUS word assembly
   always_comb begin
      status = '0;
      status[ST_BUSY]     = busy;
      status[ST_DONE]     = done_q;
      status[ST_UNDERRUN] = und_q;
      status[ST_WRAP]     = wrap_bit;
      status[ST_FRAME_LSB +: FRAME_W] = frame_q;
   end

   // Read mux; CTRL and RAM space read back as zero
   always_comb begin
      rd_mux = '0;
      if (!bus_addr[MEM_AW]) begin
         case (bus_addr[1:0])
            REG_INTERVAL: rd_mux = 32'(interval_q);
            REG_END:      rd_mux = 32'(end_q);
            REG_STATUS:   rd_mux = status;
            default:      rd_mux = '0;
         endcase
      end
   end

   // Registered read response, zero whenever not valid
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= bus_re;
         rdata_q  <= bus_re ? rd_mux : '0;
      end
   end

   ocra_grad_seq_ram #(
      .DATA_W (DATA_W),
      .AW     (MEM_AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (bus_addr[MEM_AW-1:0]),
      .wdata_i (bus_wdata[DATA_W-1:0]),
      .re_i    (ram_re),
      .raddr_i (lin_addr[MEM_AW-1:0]),
      .rdata_o (ram_rdata)
   );

   // RAM read data is only latched in FETCH, so it stays put during a stall
   assign out_valid  = send;
   assign out_ch     = send ? ch_q : 3'd0;
   assign out_data   = send ? ram_rdata : '0;
   assign irq        = irq_q;
   assign bus_rvalid = rvalid_q;
   assign bus_rdata  = rdata_q;

   logic unused_ok;
   assign unused_ok = ^{bus_wdata, bus_wdata[CTRL_LOOP], lin_addr};

endmodule
